// File: rtl/alu_pkg.sv
// Shared definitions for the ALU execute stage.
//   opcode_e : 3-bit operation codes issued by the split stage
//   state_e  : execute-stage FSM states
//   ALU_WIDTH: default operand width
package alu_pkg;

    localparam int ALU_WIDTH = 6;

    typedef enum logic [2:0] {
        OP_ADD     = 3'b000,
        OP_SUB     = 3'b001,
        OP_AND     = 3'b010,
        OP_OR      = 3'b011,
        OP_XOR     = 3'b100,
        OP_SHL     = 3'b101,
        OP_MUL     = 3'b110,
        OP_ILLEGAL = 3'b111
    } opcode_e;

    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CALC = 2'b01,
        S_DONE = 2'b10
    } state_e;

endpackage

// File: rtl/alu_mul_seq.sv
// Sequential unsigned shift-add multiplier, one partial product per cycle.
//   clock, reset : rising-edge clock, asynchronous active-high reset
//   start        : load pulse; clears the accumulator and counter
//   a, b         : operands, held stable by the caller while busy
//   done         : high during the cycle that adds the last partial product
//   product      : accumulator plus the current partial product; equals a*b
//                  while done is high
module alu_mul_seq
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 start,
    input  logic [WIDTH-1:0]     a,
    input  logic [WIDTH-1:0]     b,
    output logic                 done,
    output logic [2*WIDTH-1:0]   product
);

    localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST = CNT_W'(WIDTH - 1);

    logic [CNT_W-1:0]   cnt;
    logic               busy;
    logic [2*WIDTH-1:0] acc;
    logic [2*WIDTH-1:0] pp;

    always_comb begin
        pp = '0;
        if (b[cnt]) begin
            pp = {{WIDTH{1'b0}}, a} << cnt;
        end
    end

    // The final partial product is folded in combinationally so the caller
    // can capture the full product on the same edge that ends the iteration.
    assign product = acc + pp;
    assign done    = busy && (cnt == LAST);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            cnt  <= '0;
            busy <= 1'b0;
        end else if (start) begin
            cnt  <= '0;
            busy <= 1'b1;
        end else if (busy) begin
            if (done) begin
                cnt  <= '0;
                busy <= 1'b0;
            end else begin
                cnt  <= cnt + 1'b1;
            end
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            acc <= '0;
        end else if (start) begin
            acc <= '0;
        end else if (busy) begin
            acc <= product;
        end
    end

endmodule

// File: rtl/alu_exec.sv
// ALU execute stage: accepts one operation at a time from the split stage and
// presents a registered result with flags until the consumer takes it.
//   clock, reset         : rising-edge clock, asynchronous active-high reset
//   in_valid / in_ready  : operation handshake (control, A, B)
//   control              : opcode (see alu_pkg::opcode_e)
//   A, B                 : WIDTH-bit unsigned operands
//   out_valid / out_ready: result handshake
//   result               : 2*WIDTH-bit result
//   zero, carry, err     : result==0, carry/borrow/high-half, illegal opcode
// Single-cycle ops complete on the accept edge; MUL iterates in CALC.
module alu_exec
    import alu_pkg::*;
#(
    parameter int WIDTH = ALU_WIDTH
) (
    input  logic                 clock,
    input  logic                 reset,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           control,
    input  logic [WIDTH-1:0]     A,
    input  logic [WIDTH-1:0]     B,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   result,
    output logic                 zero,
    output logic                 carry,
    output logic                 err
);

    state_e             state, next_state;
    opcode_e            op_r, dec_op;
    logic [WIDTH-1:0]   a_r, b_r;
    logic               armed;
    logic               accept, mul_start, load_out;
    logic               mul_done;
    logic [2*WIDTH-1:0] mul_product;
    logic [2*WIDTH-1:0] ext_a, ext_b;
    logic [2*WIDTH-1:0] nres;
    logic               ncarry, nerr;

    // Holds in_ready low while reset is high and until the first edge after
    // release, so nothing can be accepted on the release edge.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) armed <= 1'b0;
        else       armed <= 1'b1;
    end

    assign in_ready  = (state == S_IDLE) && armed;
    assign out_valid = (state == S_DONE);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) state <= S_IDLE;
        else       state <= next_state;
    end

    always_comb begin
        next_state = state;
        accept     = 1'b0;
        mul_start  = 1'b0;
        load_out   = 1'b0;
        case (state)
            S_IDLE: begin
                if (in_valid && in_ready) begin
                    accept = 1'b1;
                    if (opcode_e'(control) == OP_MUL) begin
                        mul_start  = 1'b1;
                        next_state = S_CALC;
                    end else begin
                        load_out   = 1'b1;
                        next_state = S_DONE;
                    end
                end
            end
            S_CALC: begin
                if (mul_done) begin
                    load_out   = 1'b1;
                    next_state = S_DONE;
                end
            end
            S_DONE: begin
                if (out_ready) next_state = S_IDLE;
            end
            default: next_state = S_IDLE;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            op_r <= OP_ADD;
            a_r  <= '0;
            b_r  <= '0;
        end else if (accept) begin
            op_r <= opcode_e'(control);
            a_r  <= A;
            b_r  <= B;
        end
    end

    alu_mul_seq #(.WIDTH(WIDTH)) u_mul (
        .clock   (clock),
        .reset   (reset),
        .start   (mul_start),
        .a       (a_r),
        .b       (b_r),
        .done    (mul_done),
        .product (mul_product)
    );

    // In IDLE the decode works on the live inputs (single-cycle ops finish on
    // the accept edge); in CALC it works on the registered opcode (MUL).
    assign ext_a  = {{WIDTH{1'b0}}, A};
    assign ext_b  = {{WIDTH{1'b0}}, B};
    assign dec_op = (state == S_IDLE) ? opcode_e'(control) : op_r;

    always_comb begin
        nres   = '0;
        ncarry = 1'b0;
        nerr   = 1'b0;
        case (dec_op)
            OP_ADD: begin
                nres   = ext_a + ext_b;
                ncarry = nres[WIDTH];
            end
            OP_SUB: begin
                nres   = ext_a - ext_b;
                ncarry = (A < B);
            end
            OP_AND: nres = ext_a & ext_b;
            OP_OR:  nres = ext_a | ext_b;
            OP_XOR: nres = ext_a ^ ext_b;
            OP_SHL: nres = ext_a << B[2:0];
            OP_MUL: begin
                nres   = mul_product;
                ncarry = |mul_product[2*WIDTH-1:WIDTH];
            end
            OP_ILLEGAL: nerr = 1'b1;
            default:    nerr = 1'b1;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            result <= '0;
            zero   <= 1'b0;
            carry  <= 1'b0;
            err    <= 1'b0;
        end else if (load_out) begin
            result <= nres;
            zero   <= (nres == '0);
            carry  <= ncarry;
            err    <= nerr;
        end
    end

endmodule

// File: tb/tb_alu_exec.sv
module tb_alu_exec;

    logic        clock;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [2:0]  control;
    logic [5:0]  A;
    logic [5:0]  B;
    logic        out_valid;
    logic        out_ready;
    logic [11:0] result;
    logic        zero;
    logic        carry;
    logic        err;

    int n_vec = 0;
    int n_bad = 0;

    alu_exec #(.WIDTH(6)) dut (
        .clock     (clock),
        .reset     (reset),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .control   (control),
        .A         (A),
        .B         (B),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .result    (result),
        .zero      (zero),
        .carry     (carry),
        .err       (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Issue one operation from IDLE; returns the number of observation points
    // (accept edge counted as 1) until out_valid, and whether in_ready was
    // ever seen high in that window.
    task automatic do_op(input logic [2:0] c, input logic [5:0] a, input logic [5:0] b,
                         output int lat, output logic rdy_seen);
        in_valid = 1'b1;
        control  = c;
        A        = a;
        B        = b;
        @(posedge clock); #1;
        in_valid = 1'b0;
        control  = 3'b000;
        A        = '0;
        B        = '0;
        lat      = 1;
        rdy_seen = in_ready;
        while (!out_valid && lat < 40) begin
            @(posedge clock); #1;
            lat++;
            rdy_seen = rdy_seen | in_ready;
        end
    endtask

    task automatic release_out(input string tag);
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk({tag, "_ov_off"}, {31'b0, out_valid}, 32'd0);
        chk({tag, "_rdy_on"}, {31'b0, in_ready}, 32'd1);
    endtask

    int   lat;
    logic rdy_seen;

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        control   = 3'b000;
        A         = '0;
        B         = '0;

        // reset state
        repeat (3) @(posedge clock);
        #1;
        chk("rst_in_ready", {31'b0, in_ready}, 32'd0);
        chk("rst_out_valid", {31'b0, out_valid}, 32'd0);
        chk("rst_result", {20'b0, result}, 32'd0);
        chk("rst_flags", {29'b0, zero, carry, err}, 32'd0);
        reset = 1'b0;
        #1;
        chk("rel_in_ready_low", {31'b0, in_ready}, 32'd0);
        @(posedge clock); #1;
        chk("rel_in_ready_high", {31'b0, in_ready}, 32'd1);

        // ADD 63+1
        do_op(3'b000, 6'd63, 6'd1, lat, rdy_seen);
        chk("add_lat", lat, 32'd1);
        chk("add_result", {20'b0, result}, 32'h040);
        chk("add_carry", {31'b0, carry}, 32'd1);
        chk("add_zero", {31'b0, zero}, 32'd0);
        chk("add_err", {31'b0, err}, 32'd0);
        release_out("add");

        // SUB 5-7
        do_op(3'b001, 6'd5, 6'd7, lat, rdy_seen);
        chk("sub_lat", lat, 32'd1);
        chk("sub_result", {20'b0, result}, 32'hFFE);
        chk("sub_carry", {31'b0, carry}, 32'd1);
        chk("sub_zero", {31'b0, zero}, 32'd0);
        release_out("sub");

        // SHL 3 << (0x0A & 7)
        do_op(3'b101, 6'd3, 6'h0A, lat, rdy_seen);
        chk("shl_result", {20'b0, result}, 32'h00C);
        chk("shl_carry", {31'b0, carry}, 32'd0);
        release_out("shl");

        // AND / OR quick vectors
        do_op(3'b010, 6'h3C, 6'h0F, lat, rdy_seen);
        chk("and_result", {20'b0, result}, 32'h00C);
        release_out("and");
        do_op(3'b011, 6'h30, 6'h05, lat, rdy_seen);
        chk("or_result", {20'b0, result}, 32'h035);
        release_out("or");

        // MUL 63*63
        do_op(3'b110, 6'd63, 6'd63, lat, rdy_seen);
        chk("mul_lat", lat, 32'd7);
        chk("mul_rdy_low", {31'b0, rdy_seen}, 32'd0);
        chk("mul_result", {20'b0, result}, 32'hF81);
        chk("mul_carry", {31'b0, carry}, 32'd1);
        chk("mul_err", {31'b0, err}, 32'd0);
        release_out("mul");

        // MUL small: 5*3, high half zero
        do_op(3'b110, 6'd5, 6'd3, lat, rdy_seen);
        chk("mul2_result", {20'b0, result}, 32'h00F);
        chk("mul2_carry", {31'b0, carry}, 32'd0);
        release_out("mul2");

        // reset 3 cycles into MUL (previous result is nonzero)
        in_valid = 1'b1;
        control  = 3'b110;
        A        = 6'd63;
        B        = 6'd63;
        @(posedge clock); #1;
        in_valid = 1'b0;
        repeat (3) @(posedge clock);
        #1;
        reset = 1'b1;
        #1;
        chk("abort_result", {20'b0, result}, 32'd0);
        chk("abort_flags", {29'b0, zero, carry, err}, 32'd0);
        chk("abort_out_valid", {31'b0, out_valid}, 32'd0);
        chk("abort_in_ready", {31'b0, in_ready}, 32'd0);
        @(posedge clock); #1;
        reset = 1'b0;
        @(posedge clock); #1;
        chk("abort_rdy_back", {31'b0, in_ready}, 32'd1);
        repeat (8) @(posedge clock);
        #1;
        chk("abort_no_result", {31'b0, out_valid}, 32'd0);

        do_op(3'b000, 6'd2, 6'd3, lat, rdy_seen);
        chk("add2_lat", lat, 32'd1);
        chk("add2_result", {20'b0, result}, 32'h005);
        chk("add2_carry", {31'b0, carry}, 32'd0);
        release_out("add2");

        // backpressure with XOR 0x2A^0x2A
        do_op(3'b100, 6'h2A, 6'h2A, lat, rdy_seen);
        chk("xor_lat", lat, 32'd1);
        in_valid = 1'b1;
        control  = 3'b000;
        A        = 6'd1;
        B        = 6'd1;
        for (int i = 0; i < 5; i++) begin
            @(posedge clock); #1;
            chk("bp_out_valid", {31'b0, out_valid}, 32'd1);
            chk("bp_result", {20'b0, result}, 32'd0);
            chk("bp_zero", {31'b0, zero}, 32'd1);
            chk("bp_in_ready", {31'b0, in_ready}, 32'd0);
        end
        out_ready = 1'b1;
        @(posedge clock); #1;
        out_ready = 1'b0;
        chk("bp_ov_drop", {31'b0, out_valid}, 32'd0);
        chk("bp_rdy_back", {31'b0, in_ready}, 32'd1);
        @(posedge clock); #1;
        in_valid = 1'b0;
        chk("bp_accept_ov", {31'b0, out_valid}, 32'd1);
        chk("bp_accept_result", {20'b0, result}, 32'h002);
        release_out("bp");

        // illegal opcode
        do_op(3'b111, 6'd1, 6'd1, lat, rdy_seen);
        chk("ill_lat", lat, 32'd1);
        chk("ill_result", {20'b0, result}, 32'd0);
        chk("ill_zero", {31'b0, zero}, 32'd1);
        chk("ill_err", {31'b0, err}, 32'd1);
        chk("ill_carry", {31'b0, carry}, 32'd0);
        release_out("ill");

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/alu_exec.md
ALU_EXEC -- requirements
Module: alu_exec

Interface
REQ-001 SHALL have parameter WIDTH, default 6, operand width; result width is 2*WIDTH.
REQ-002 SHALL have port clock  input  1  rising-edge clock.
REQ-003 SHALL have port reset  input  1  asynchronous, active-high reset.
REQ-004 SHALL have port in_valid  input  1  upstream split stage presents control/A/B.
REQ-005 SHALL have port in_ready  output  1  block can accept an operation.
REQ-006 SHALL have port control  input  3  opcode from split stage.
REQ-007 SHALL have port A  input  WIDTH  first operand from split stage.
REQ-008 SHALL have port B  input  WIDTH  second operand from split stage.
REQ-009 SHALL have port out_valid  output  1  result and flags valid.
REQ-010 SHALL have port out_ready  input  1  downstream accepts result.
REQ-011 SHALL have port result  output  2*WIDTH  operation result.
REQ-012 SHALL have port zero  output  1  result equals 0.
REQ-013 SHALL have port carry  output  1  carry/borrow/high-half flag.
REQ-014 SHALL have port err  output  1  illegal opcode.

Function
REQ-015 SHALL implement FSM states IDLE, CALC, DONE; in_ready = 1 only in IDLE.
REQ-016 SHALL accept on a rising edge with in_valid & in_ready, registering control, A, B.
REQ-017 SHALL, for opcodes 000-101 and 111, register result/flags on the accept edge and enter DONE (out_valid one cycle after accept).
REQ-018 SHALL decode: 000 ADD, 001 SUB, 010 AND, 011 OR, 100 XOR, 101 SHL, 110 MUL, 111 illegal.
REQ-019 SHALL compute ADD as zero-extended A+B; carry = bit WIDTH of the sum.
REQ-020 SHALL compute SUB as A-B in 2*WIDTH two's complement (sign-extended); carry = 1 when A<B (borrow).
REQ-021 SHALL compute AND/OR/XOR zero-extended; carry = 0.
REQ-022 SHALL compute SHL as zero-extended A shifted left by B[2:0]; B[WIDTH-1:3] ignored; carry = 0.
REQ-023 SHALL compute MUL unsigned via shift-add, one partial product per cycle in CALC, WIDTH iterations; out_valid exactly WIDTH+1 cycles after accept.
REQ-024 SHALL set carry for MUL when result[2*WIDTH-1:WIDTH] is nonzero.
REQ-025 SHALL, for opcode 111, output result 0, zero 1, carry 0, err 1; err = 0 for all other opcodes.
REQ-026 SHALL set zero = (result == 0) for every opcode.
REQ-027 SHALL hold result, flags and out_valid stable in DONE until out_ready is sampled high, then return to IDLE.
REQ-028 SHALL ignore in_valid, control, A, B in CALC and DONE (no accept, no operand change).
REQ-029 SHALL keep the iteration counter within 0..WIDTH-1, with no wrap past WIDTH.

Reset
REQ-030 SHALL, on reset assertion at any time including mid-CALC, immediately force state IDLE, out_valid 0, result 0, zero 0, carry 0, err 0, and clear the counter and operand registers.
REQ-031 SHALL drive in_ready 0 while reset is high and 1 from the first rising edge after deassertion.
REQ-032 SHALL discard any aborted operation; no result for it is ever presented.

Structure
REQ-033 SHALL take from shared package alu_pkg: opcode enum (ADD..ILLEGAL), FSM state enum, WIDTH default constant.
REQ-034 SHALL place the shift-add multiplier in sub-module alu_mul_seq (start, done, WIDTH-parameterized), instantiated once.
REQ-035 SHALL use one always_ff block per register group and a combinational next-state/decode block.

Verification
REQ-036 SHALL verify ADD A=63, B=1 -> result 0x040, carry 1, zero 0, err 0, out_valid one cycle after accept.
REQ-037 SHALL verify SUB A=5, B=7 -> result 0xFFE, carry 1; then SHL A=3, B=0x0A -> result 0x00C.
REQ-038 SHALL verify MUL A=63, B=63 -> result 0xF81, carry 1, out_valid exactly 7 cycles after accept, in_ready 0 throughout.
REQ-039 SHALL verify backpressure: out_ready held 0 for 5 cycles after XOR A=0x2A, B=0x2A -> result 0, zero 1 held stable; new in_valid ignored; accepted the cycle after out_ready=1.
REQ-040 SHALL verify reset asserted 3 cycles into MUL -> all outputs 0 immediately; a following ADD A=2, B=3 yields 0x005.
REQ-041 SHALL verify control=111, A=1, B=1 -> result 0, zero 1, err 1, carry 0.
